// File: rtl/dconv_acq_ctrl_if.sv
// Bus bundle between the downconverter acquisition controller and its user:
// run requests and ADC samples in, LO control and run status out.
interface dconv_acq_ctrl_if #(
    parameter int ADC_PHYS_WIDTH = 14,
    parameter int CNT_WIDTH      = 16
);
    logic                        start;
    logic                        abort;
    logic                        cal_en;
    logic [ADC_PHYS_WIDTH:0]     dcval_manual;
    logic [CNT_WIDTH-1:0]        num_groups;
    logic [ADC_PHYS_WIDTH-1:0]   adc_data_in;

    logic [ADC_PHYS_WIDTH:0]     adc_dcval_subtractor;
    logic                        conv_en;
    logic                        dconv_rst;
    logic                        busy;
    logic                        done;
    logic [CNT_WIDTH-1:0]        group_cnt;

    // Requester side: issues runs and supplies samples.
    modport master (
        output start, abort, cal_en, dcval_manual, num_groups, adc_data_in,
        input  adc_dcval_subtractor, conv_en, dconv_rst, busy, done, group_cnt
    );

    // Controller side.
    modport slave (
        input  start, abort, cal_en, dcval_manual, num_groups, adc_data_in,
        output adc_dcval_subtractor, conv_en, dconv_rst, busy, done, group_cnt
    );
endinterface

// File: rtl/dconv_acq_ctrl.sv
// dconv_acq_ctrl: sequences an optional DC calibration, a one-cycle LO phase
// alignment and an acquisition of whole 4-sample LO groups for a digital
// downconverter. All outputs come straight from flops.
module dconv_acq_ctrl #(
    parameter int ADC_PHYS_WIDTH = 14,
    parameter int CAL_LOG2       = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    dconv_acq_ctrl_if.slave bus
);
    localparam int W     = ADC_PHYS_WIDTH;
    localparam int ACC_W = W + CAL_LOG2;
    localparam logic [CAL_LOG2-1:0]  CAL_ONE = CAL_LOG2'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, CAL, ALIGN, ACQ, DONE} state_t;

    state_t                state;
    state_t                state_next;

    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      acc_sum;
    logic [CAL_LOG2-1:0]   cal_cnt;
    logic [1:0]            phase;
    logic [CNT_WIDTH-1:0]  groups_target;
    logic [CNT_WIDTH-1:0]  group_cnt;
    logic [W:0]            subtractor;
    logic                  conv_en;
    logic                  dconv_rst;
    logic                  busy;
    logic                  done;
    logic                  last_sample;
    logic                  last_group;

    // The accumulator is wide enough for 2^CAL_LOG2 full-scale samples, so
    // the running sum never overflows.
    assign acc_sum     = acc + {{CAL_LOG2{1'b0}}, bus.adc_data_in};
    assign last_sample = (cal_cnt == '1);
    assign last_group  = (phase == 2'd3) && (group_cnt == groups_target - CNT_ONE);

    // Next-state decode; abort wins over every other transition in the active states.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = bus.cal_en ? CAL : ALIGN;
                end
            end
            CAL: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (last_sample) begin
                    state_next = ALIGN;
                end
            end
            ALIGN: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (groups_target != '0) begin
                    state_next = ACQ;
                end else begin
                    state_next = DONE;
                end
            end
            ACQ: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (last_group) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered outputs decoded from the next state, plus the calibration
    // accumulator, the group counters and the DC subtractor.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            conv_en       <= 1'b0;
            dconv_rst     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            acc           <= '0;
            cal_cnt       <= '0;
            phase         <= '0;
            groups_target <= '0;
            group_cnt     <= '0;
            subtractor    <= '0;
        end else begin
            conv_en   <= (state_next == ACQ);
            dconv_rst <= (state_next == ALIGN);
            busy      <= (state_next != IDLE);
            done      <= (state_next == DONE);

            if (state == IDLE && bus.start) begin
                groups_target <= bus.num_groups;
                acc           <= '0;
                cal_cnt       <= '0;
                if (!bus.cal_en) begin
                    subtractor <= bus.dcval_manual;
                end
            end

            if (state == CAL && !bus.abort) begin
                acc     <= acc_sum;
                cal_cnt <= cal_cnt + CAL_ONE;
                if (last_sample) begin
                    subtractor <= {1'b0, acc_sum[ACC_W-1:CAL_LOG2]};
                end
            end

            if (state_next == ALIGN) begin
                group_cnt <= '0;
                phase     <= '0;
            end

            if (state == ACQ) begin
                phase <= phase + 2'd1;
                if (phase == 2'd3) begin
                    group_cnt <= group_cnt + CNT_ONE;
                end
            end
        end
    end

    assign bus.conv_en              = conv_en;
    assign bus.dconv_rst            = dconv_rst;
    assign bus.busy                 = busy;
    assign bus.done                 = done;
    assign bus.group_cnt            = group_cnt;
    assign bus.adc_dcval_subtractor = subtractor;
endmodule

// File: doc/dconv_acq_ctrl.md
DCONV_ACQ_CTRL -- requirements
Module: dconv_acq_ctrl

Interface
REQ-001 SHALL have parameter ADC_PHYS_WIDTH, default 14, ADC sample width W.
REQ-002 SHALL have parameter CAL_LOG2, default 4, log2 of DC-calibration sample count.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the group counter.
REQ-004 SHALL have port CLK  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  single-cycle acquisition request.
REQ-007 SHALL have port abort  input  1  terminate acquisition.
REQ-008 SHALL have port cal_en  input  1  1 = measure DC before acquiring, 0 = use dcval_manual.
REQ-009 SHALL have port dcval_manual  input  W+1  signed DC subtractor used when cal_en=0.
REQ-010 SHALL have port num_groups  input  CNT_WIDTH  number of 4-sample LO groups to acquire.
REQ-011 SHALL have port adc_data_in  input  W  unsigned ADC sample, one per CLK.
REQ-012 SHALL have port adc_dcval_subtractor  output  W+1  DC subtractor driven to the downconverter.
REQ-013 SHALL have port conv_en  output  1  downconverter LO-phase advance enable, also I/Q sample valid.
REQ-014 SHALL have port dconv_rst  output  1  one-cycle pulse resetting the downconverter LO phase to 0.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse on normal completion.
REQ-017 SHALL have port group_cnt  output  CNT_WIDTH  groups completed in the current acquisition.

Function
REQ-018 SHALL implement the states IDLE, CAL, ALIGN, ACQ and DONE; all outputs registered.
REQ-019 SHALL capture start and all inputs (cal_en, dcval_manual, num_groups) only in IDLE; start outside IDLE SHALL be ignored.
REQ-020 SHALL transition IDLE->CAL on start with cal_en=1, and IDLE->ALIGN on start with cal_en=0, one cycle after start.
REQ-021 SHALL, in CAL, accumulate exactly 2^CAL_LOG2 consecutive samples into a W+CAL_LOG2-bit unsigned accumulator cleared on CAL entry, then go to ALIGN.
REQ-022 SHALL, on leaving CAL, load adc_dcval_subtractor = {1'b0, acc >> CAL_LOG2} (truncating).
REQ-023 SHALL, on IDLE->ALIGN with cal_en=0, load adc_dcval_subtractor = dcval_manual.
REQ-024 SHALL hold adc_dcval_subtractor between acquisitions; only REQ-022/REQ-023 or reset change it.
REQ-025 SHALL assert dconv_rst for exactly the one ALIGN cycle; ALIGN lasts one cycle.
REQ-026 SHALL go ALIGN->ACQ if the latched num_groups>0, else ALIGN->DONE with conv_en never asserted.
REQ-027 SHALL hold conv_en high for exactly 4*num_groups consecutive cycles in ACQ, so the LO phase ends at 0.
REQ-028 SHALL increment group_cnt after every 4th conv_en cycle; group_cnt clears on ALIGN entry.
REQ-029 SHALL go ACQ->DONE after the final conv_en cycle, pulse done for the single DONE cycle, then return to IDLE.
REQ-030 SHALL, on abort in CAL, ALIGN or ACQ, go to IDLE the next cycle with conv_en low; done SHALL NOT pulse.
REQ-031 SHALL keep adc_dcval_subtractor unchanged on an abort during CAL.
REQ-032 SHALL give abort priority over every other transition in the same cycle.
REQ-033 SHALL give num_groups = 2^CNT_WIDTH-1 full-length acquisition, with no counter wrap before DONE.

Reset
REQ-034 SHALL, on RESET, asynchronously force the state to IDLE with conv_en=0, dconv_rst=0, busy=0, done=0, group_cnt=0, adc_dcval_subtractor=0 and the accumulator cleared.
REQ-035 SHALL, on RESET asserted mid-CAL or mid-ACQ, abandon the operation, with no done pulse after release.

Verification
REQ-036 SHALL verify: W=14, CAL_LOG2=4, cal_en=1, adc constant 8200, num_groups=2 -> subtractor=8200, one dconv_rst pulse, conv_en high exactly 8 cycles, group_cnt=2, one done.
REQ-037 SHALL verify: cal_en=1, adc ramp 0..15 during CAL -> subtractor=7 (sum 120 >> 4).
REQ-038 SHALL verify: cal_en=0, dcval_manual=0x1F00, num_groups=0 -> subtractor=0x1F00, conv_en never high, done 2 cycles after start.
REQ-039 SHALL verify: abort on the 5th conv_en cycle of num_groups=3 -> conv_en low next cycle, busy=0, no done, group_cnt=1.
REQ-040 SHALL verify: start pulsed during ACQ and num_groups changed mid-run -> ignored, the original count completes.
REQ-041 SHALL verify: RESET mid-CAL -> all outputs 0 immediately; a new start after release runs a full 16-sample CAL.
